// File: rtl/cpu_consts.sv
// Shared CPU constants and types used by the writeback stage.
package cpu_consts;

  typedef struct packed {
    logic [4:0] rd;
    logic       wb_en;
  } wb_tag_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  function automatic logic [31:0] reg_onehot(input logic [4:0] r);
    reg_onehot = 32'd1 << r;
  endfunction

endpackage

// File: rtl/wb_tag_fifo.sv
// In-order FIFO of writeback destination tags; one entry per in-flight instruction.
module wb_tag_fifo
  import cpu_consts::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic                  push,
  input  wb_tag_t               push_tag,
  input  logic                  pop,
  output wb_tag_t               head,
  output logic                  full,
  output logic                  empty,
  output logic [CW-1:0]         count,
  output wb_tag_t [DEPTH-1:0]   entries,
  output logic [DEPTH-1:0]      valid
);

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  assign head  = entries[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Pop clears before push sets, so a push+pop on a full FIFO (same slot) leaves it valid.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      valid   <= '0;
      entries <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      if (push) begin
        entries[wr_ptr] <= push_tag;
        valid[wr_ptr]   <= 1'b1;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/exu_writeback.sv
// Writeback stage: pairs execute results with in-order destination tags and drives
// a registered one-cycle register-file write port plus a pending-register mask.
module exu_writeback
  import cpu_consts::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush_i,
  input  logic        issue_valid_i,
  input  logic [4:0]  issue_rd_i,
  input  logic        issue_wb_en_i,
  output logic        issue_ready_o,
  input  logic        res_valid_i,
  input  logic [63:0] res_i,
  output logic        res_ready_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [63:0] rf_wdata_o,
  output logic [31:0] pending_o,
  output logic        idle_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // ready never depends on the same channel's valid, and flush blocks both channels.
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [CW-1:0]      count;
  wb_tag_t            head;
  wb_tag_t            push_tag;
  wb_tag_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]   valid;
  logic [31:0]        pend;

  assign res_ready_o   = ~empty & ~flush_i;
  assign pop           = res_valid_i & res_ready_o;
  assign issue_ready_o = ~full | pop;
  assign push          = issue_valid_i & issue_ready_o & ~flush_i;
  assign push_tag      = '{rd: issue_rd_i, wb_en: issue_wb_en_i};

  wb_tag_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (flush_i),
    .push     (push),
    .push_tag (push_tag),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .entries  (entries),
    .valid    (valid)
  );

  // Address/data follow every pop; the enable only fires for real register writes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
    end else if (pop) begin
      rf_we_o    <= head.wb_en && (head.rd != REG_X0);
      rf_waddr_o <= head.rd;
      rf_wdata_o <= res_i;
    end else begin
      rf_we_o <= 1'b0;
    end
  end

  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && entries[i].wb_en) pend = pend | reg_onehot(entries[i].rd);
    end
    if (rf_we_o) pend = pend | reg_onehot(rf_waddr_o);
    pend[0] = 1'b0;
  end

  assign pending_o = pend;
  assign idle_o    = empty & ~rf_we_o;

  a_res_needs_tag: assert property (@(posedge clk) disable iff (!resetn) res_valid_i |-> !empty);
  a_count_bound:   assert property (@(posedge clk) disable iff (!resetn) count <= CW'(DEPTH));

endmodule

// File: tb/tb_exu_writeback.sv
// Bench for exu_writeback: randomized and directed traffic against a queue-based model.
module tb_exu_writeback;
  import cpu_consts::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush_i = 1'b0;
  logic        issue_valid_i = 1'b0;
  logic [4:0]  issue_rd_i = '0;
  logic        issue_wb_en_i = 1'b0;
  logic        issue_ready_o;
  logic        res_valid_i = 1'b0;
  logic [63:0] res_i = '0;
  logic        res_ready_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [63:0] rf_wdata_o;
  logic [31:0] pending_o;
  logic        idle_o;

  exu_writeback #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .flush_i       (flush_i),
    .issue_valid_i (issue_valid_i),
    .issue_rd_i    (issue_rd_i),
    .issue_wb_en_i (issue_wb_en_i),
    .issue_ready_o (issue_ready_o),
    .res_valid_i   (res_valid_i),
    .res_i         (res_i),
    .res_ready_o   (res_ready_o),
    .rf_we_o       (rf_we_o),
    .rf_waddr_o    (rf_waddr_o),
    .rf_wdata_o    (rf_wdata_o),
    .pending_o     (pending_o),
    .idle_o        (idle_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- model and scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [84:0] exp_q[$];   // {cycle[15:0], addr[4:0], data[63:0]} of each expected rf write
  logic [5:0]  mq[$];      // in-flight tags {rd, wb_en}, oldest first
  logic        m_we = 1'b0;
  logic [4:0]  m_addr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_pending();
    logic [31:0] p = '0;
    foreach (mq[i]) if (mq[i][0] && mq[i][5:1] != 5'd0) p[mq[i][5:1]] = 1'b1;
    if (m_we) p[m_addr] = 1'b1;
    return p;
  endfunction

  // ---------------- driver ----------------
  task automatic cycle(input logic iv, input logic [4:0] rd, input logic wen,
                       input logic rv, input logic [63:0] d, input logic fl);
    logic exp_rr, exp_ir, do_pop, do_push;
    logic [5:0] t;
    @(negedge clk);
    issue_valid_i = iv;
    issue_rd_i    = rd;
    issue_wb_en_i = wen;
    res_valid_i   = rv;
    res_i         = d;
    flush_i       = fl;
    #1;
    exp_rr  = (mq.size() != 0) && !fl;
    do_pop  = rv && exp_rr;
    exp_ir  = (mq.size() != DEPTH) || do_pop;
    do_push = iv && exp_ir && !fl;
    chk("res_ready", 64'(res_ready_o), 64'(exp_rr));
    chk("issue_ready", 64'(issue_ready_o), 64'(exp_ir));
    m_we = 1'b0;
    if (fl) begin
      mq.delete();
    end else begin
      if (do_pop) begin
        t = mq.pop_front();
        if (t[0] && t[5:1] != 5'd0) begin
          m_we   = 1'b1;
          m_addr = t[5:1];
          exp_q.push_back({16'(cyc + 1), t[5:1], d});
        end
      end
      if (do_push) mq.push_back({rd, wen});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 1'b0, 1'b0, 64'd0, 1'b0);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    logic [84:0] e;
    cyc++;
    #1;
    if (resetn) begin
      if (rf_we_o) begin
        if (exp_q.size() == 0) begin
          chk("rf_we_unexpected", 64'(rf_we_o), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rf_waddr", 64'(rf_waddr_o), 64'(e[68:64]));
          chk("rf_wdata", rf_wdata_o, e[63:0]);
          chk("rf_write_cycle", 64'(cyc), 64'(e[84:69]));
        end
      end
      chk("pending", 64'(pending_o), 64'(model_pending()));
      chk("idle", 64'(idle_o), 64'((mq.size() == 0) && !m_we));
    end
  end

  task automatic chk_reset_values();
    chk("rst_rf_we", 64'(rf_we_o), 64'd0);
    chk("rst_waddr", 64'(rf_waddr_o), 64'd0);
    chk("rst_wdata", rf_wdata_o, 64'd0);
    chk("rst_pending", 64'(pending_o), 64'd0);
    chk("rst_issue_ready", 64'(issue_ready_o), 64'd1);
    chk("rst_res_ready", 64'(res_ready_o), 64'd0);
    chk("rst_idle", 64'(idle_o), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic iv, wen, rv, fl;
    logic [4:0] rd;
    #2;
    chk_reset_values();
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // 1: single write with data one cycle after pop
    cycle(1'b1, 5'd5, 1'b1, 1'b0, 64'd0, 1'b0);
    cycle(1'b0, 5'd0, 1'b0, 1'b1, 64'hDEAD_BEEF, 1'b0);
    idle(2);

    // 2: x0 and no-write ops pop silently
    cycle(1'b1, 5'd0, 1'b1, 1'b0, 64'd0, 1'b0);
    cycle(1'b1, 5'd7, 1'b0, 1'b1, 64'h1111, 1'b0);
    cycle(1'b0, 5'd0, 1'b0, 1'b1, 64'h2222, 1'b0);
    idle(2);

    // 3: fill, blocked issue, push+pop while full, in-order drain
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 5'(i), 1'b1, 1'b0, 64'd0, 1'b0);
    cycle(1'b1, 5'd11, 1'b1, 1'b0, 64'd0, 1'b0);
    cycle(1'b1, 5'd10, 1'b1, 1'b1, 64'hA1, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 5'd0, 1'b0, 1'b1, 64'hB0 + 64'(i), 1'b0);
    idle(2);

    // 4: flush discards a queued tag; later issue pairs with next result
    cycle(1'b1, 5'd9, 1'b1, 1'b0, 64'd0, 1'b0);
    cycle(1'b0, 5'd0, 1'b0, 1'b0, 64'd0, 1'b1);
    idle(1);
    cycle(1'b1, 5'd3, 1'b1, 1'b0, 64'd0, 1'b0);
    cycle(1'b0, 5'd0, 1'b0, 1'b1, 64'h3333, 1'b0);
    idle(2);

    // 5: registered write completes across a flush, nothing after it
    cycle(1'b1, 5'd6, 1'b1, 1'b0, 64'd0, 1'b0);
    cycle(1'b1, 5'd8, 1'b1, 1'b1, 64'h6666, 1'b0);
    cycle(1'b0, 5'd0, 1'b0, 1'b1, 64'h8888, 1'b1);
    idle(3);

    // 6: asynchronous reset with 3 tags queued and a write on the port
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 5'd12 + 5'(i), 1'b1, 1'b0, 64'd0, 1'b0);
    cycle(1'b0, 5'd0, 1'b0, 1'b1, 64'hC0C0, 1'b0);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    issue_valid_i = 1'b0;
    res_valid_i = 1'b0;
    flush_i = 1'b0;
    #1;
    chk_reset_values();
    mq.delete();
    exp_q.delete();
    m_we = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // random traffic
    for (int n = 0; n < 400; n++) begin
      iv  = 1'($urandom_range(0, 1));
      rd  = 5'($urandom_range(0, 31));
      wen = ($urandom_range(0, 3) != 0);
      rv  = (mq.size() != 0) && ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 40) == 0);
      cycle(iv, rd, wen, rv, {$urandom, $urandom}, fl);
    end
    for (int n = 0; n < 3 * DEPTH && mq.size() != 0; n++)
      cycle(1'b0, 5'd0, 1'b0, 1'b1, {$urandom, $urandom}, 1'b0);
    idle(3);

    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
